rvsteel_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single manager port of `rvsteel_bus` between `NUM_MANAGERS` requesters, such as `rvsteel_core` and a DMA engine.
- Accepts one read or write request at a time from the requesters.
- Latches the winning request and issues it downstream as a one-cycle pulse.
- Waits for the device response, then returns it only to the granted requester.
- Keeps exactly one transaction outstanding system-wide.

---
 rtl/rvsteel_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rvsteel_bus_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_bus_arbiter.sv
// rvsteel_bus_arbiter: round-robin arbiter that shares the single manager port
// of rvsteel_bus between NUM_MANAGERS requesters. Exactly one transaction is
// outstanding at a time; the winner's request is latched, issued downstream as
// a one-cycle pulse, and the device response is routed back to the granted
// requester only.
//
// Optional feature: define RVSTEEL_BUS_ARBITER_TIMEOUT_EN to force completion
// (zero read data, timeout_error pulse) after TIMEOUT_CYCLES cycles without a
// downstream response. Without it the arbiter waits indefinitely.
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   mgr_*  (inputs)           per-requester address/data/strobe/read/write
//   mgr_read_data             shared read data (mirrors bus_read_data)
//   mgr_read/write_response   per-requester completion pulses (combinational)
//   bus_*  (outputs)          latched request towards rvsteel_bus
//   bus_*  (inputs)           downstream read data and completion pulses
//   grant                     one-hot owner of the current transaction
//   timeout_error             pulse on a forced (timeout) completion

module rvsteel_bus_arbiter #(
    parameter int unsigned NUM_MANAGERS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_MANAGERS*32-1:0]   mgr_rw_address,
    input  logic [NUM_MANAGERS-1:0]      mgr_read_request,
    input  logic [NUM_MANAGERS-1:0]      mgr_write_request,
    input  logic [NUM_MANAGERS*32-1:0]   mgr_write_data,
    input  logic [NUM_MANAGERS*4-1:0]    mgr_write_strobe,
    output logic [31:0]                  mgr_read_data,
    output logic [NUM_MANAGERS-1:0]      mgr_read_response,
    output logic [NUM_MANAGERS-1:0]      mgr_write_response,
    output logic [31:0]                  bus_rw_address,
    output logic [31:0]                  bus_write_data,
    output logic [3:0]                   bus_write_strobe,
    output logic                         bus_read_request,
    output logic                         bus_write_request,
    input  logic [31:0]                  bus_read_data,
    input  logic                         bus_read_response,
    input  logic                         bus_write_response,
    output logic [NUM_MANAGERS-1:0]      grant,
    output logic                         timeout_error
);

    localparam int unsigned IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

    // Reject illegal configurations at elaboration.
    if (NUM_MANAGERS < 2 || NUM_MANAGERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
    begin : g_bad_params
        $error("rvsteel_bus_arbiter: NUM_MANAGERS must be 2..8, TIMEOUT_CYCLES 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          last_grant;
    logic                      is_write;
    logic [NUM_MANAGERS-1:0]   pending;
    logic                      found;
    logic [IDX_W-1:0]          win;
    logic [IDX_W-1:0]          cand;
    logic                      match;
    logic                      timeout_hit;
    logic                      complete;

    assign pending = mgr_read_request | mgr_write_request;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_MANAGERS); k++) begin
            cand = IDX_W'((int'(last_grant) + k) % int'(NUM_MANAGERS));
            if (!found && pending[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Only a response of the latched type counts, and never while idle.
    always_comb begin
        match = 1'b0;
        if (state != IDLE) begin
            match = is_write ? bus_write_response : bus_read_response;
        end
    end

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
    logic [7:0] tmo_count;

    // A real response in the same cycle wins over the timeout.
    assign timeout_hit = (state != IDLE) && !match && (tmo_count == 8'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = match | timeout_hit;

    // Completion routing: only the granted requester ever sees a pulse.
    assign mgr_read_response  = {NUM_MANAGERS{complete & ~is_write}} & grant;
    assign mgr_write_response = {NUM_MANAGERS{complete &  is_write}} & grant;
    assign mgr_read_data      = timeout_hit ? 32'h0 : bus_read_data;
    assign timeout_error      = timeout_hit;

    // Arbitration FSM with registered grant and downstream request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            last_grant        <= IDX_W'(NUM_MANAGERS - 1);
            is_write          <= 1'b0;
            grant             <= '0;
            bus_rw_address    <= '0;
            bus_write_data    <= '0;
            bus_write_strobe  <= '0;
            bus_read_request  <= 1'b0;
            bus_write_request <= 1'b0;
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
            tmo_count         <= '0;
`endif
        end else begin
            bus_read_request  <= 1'b0;
            bus_write_request <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        // Write wins over a simultaneous read from the same requester.
                        is_write          <= mgr_write_request[win];
                        bus_write_request <= mgr_write_request[win];
                        bus_read_request  <= ~mgr_write_request[win];
                        grant             <= NUM_MANAGERS'(1) << win;
                        last_grant        <= win;
                        bus_rw_address    <= mgr_rw_address[int'(win)*32 +: 32];
                        bus_write_data    <= mgr_write_data[int'(win)*32 +: 32];
                        bus_write_strobe  <= mgr_write_strobe[int'(win)*4 +: 4];
                        state             <= ISSUE;
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
                        tmo_count         <= '0;
`endif
                    end
                end
                ISSUE, WAIT: begin
                    if (complete) begin
                        grant <= '0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
                        tmo_count <= tmo_count + 8'd1;
`endif
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Self-checking bench for rvsteel_bus_arbiter (NUM_MANAGERS=2). Expected
// completions are queued by the scenario tasks when they drive the device
// response and are checked by a monitor on every falling clock edge.

module tb_rvsteel_bus_arbiter;

    localparam int unsigned N = 2;

    logic              clock;
    logic              reset;
    logic [N*32-1:0]   mgr_rw_address;
    logic [N-1:0]      mgr_read_request;
    logic [N-1:0]      mgr_write_request;
    logic [N*32-1:0]   mgr_write_data;
    logic [N*4-1:0]    mgr_write_strobe;
    logic [31:0]       mgr_read_data;
    logic [N-1:0]      mgr_read_response;
    logic [N-1:0]      mgr_write_response;
    logic [31:0]       bus_rw_address;
    logic [31:0]       bus_write_data;
    logic [3:0]        bus_write_strobe;
    logic              bus_read_request;
    logic              bus_write_request;
    logic [31:0]       bus_read_data;
    logic              bus_read_response;
    logic              bus_write_response;
    logic [N-1:0]      grant;
    logic              timeout_error;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] data;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rvsteel_bus_arbiter #(
        .NUM_MANAGERS   (N),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mgr_rw_address     (mgr_rw_address),
        .mgr_read_request   (mgr_read_request),
        .mgr_write_request  (mgr_write_request),
        .mgr_write_data     (mgr_write_data),
        .mgr_write_strobe   (mgr_write_strobe),
        .mgr_read_data      (mgr_read_data),
        .mgr_read_response  (mgr_read_response),
        .mgr_write_response (mgr_write_response),
        .bus_rw_address     (bus_rw_address),
        .bus_write_data     (bus_write_data),
        .bus_write_strobe   (bus_write_strobe),
        .bus_read_request   (bus_read_request),
        .bus_write_request  (bus_write_request),
        .bus_read_data      (bus_read_data),
        .bus_read_response  (bus_read_response),
        .bus_write_response (bus_write_response),
        .grant              (grant),
        .timeout_error      (timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: every completion pulse must match the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if ((mgr_read_response | mgr_write_response) != '0 || timeout_error) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response rd=%b wr=%b tmo=%b (none expected)",
                             mgr_read_response, mgr_write_response, timeout_error);
                end else begin
                    automatic exp_t       e   = sb.pop_front();
                    automatic logic [N-1:0] vec = N'(1) << e.idx;
                    automatic logic [N-1:0] erd = e.wr ? '0 : vec;
                    automatic logic [N-1:0] ewr = e.wr ? vec : '0;
                    if (mgr_read_response !== erd || mgr_write_response !== ewr ||
                        timeout_error !== e.tmo || (!e.wr && mgr_read_data !== e.data)) begin
                        errors++;
                        $display("FAIL completion rd=%b wr=%b data=%h tmo=%b, expected rd=%b wr=%b data=%h tmo=%b",
                                 mgr_read_response, mgr_write_response, mgr_read_data, timeout_error,
                                 erd, ewr, e.data, e.tmo);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mgr();
        mgr_rw_address    = '0;
        mgr_read_request  = '0;
        mgr_write_request = '0;
        mgr_write_data    = '0;
        mgr_write_strobe  = '0;
    endtask

    task automatic set_req(input int idx, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        mgr_rw_address[idx*32 +: 32]  = addr;
        mgr_write_data[idx*32 +: 32]  = wdata;
        mgr_write_strobe[idx*4 +: 4]  = strb;
        mgr_read_request[idx]         = rd;
        mgr_write_request[idx]        = wr;
    endtask

    // Ticks until a downstream request pulse shows up (bounded); n = cycles taken.
    task automatic wait_issue(output int n);
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (!(bus_read_request | bus_write_request) && n < 10);
        checks++;
        if (!(bus_read_request | bus_write_request)) begin
            errors++;
            $display("FAIL issue_timeout no bus request after %0d cycles, expected a pulse", n);
        end
    endtask

    // One complete transaction from requester idx; device answers lat cycles after issue.
    task automatic do_txn(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] rdata, input int lat);
        int n;
        logic [N-1:0] g;
        g = N'(1) << idx;
        set_req(idx, !wr, wr, addr, wdata, strb);
        wait_issue(n);
        checks++;
        if (n !== 1 || grant !== g || bus_write_request !== wr || bus_read_request !== !wr ||
            bus_rw_address !== addr) begin
            errors++;
            $display("FAIL issue n=%0d grant=%b rd=%b wr=%b addr=%h, expected n=1 grant=%b rd=%b wr=%b addr=%h",
                     n, grant, bus_read_request, bus_write_request, bus_rw_address, g, !wr, wr, addr);
        end
        if (wr) begin
            checks++;
            if (bus_write_data !== wdata || bus_write_strobe !== strb) begin
                errors++;
                $display("FAIL write_payload data=%h strb=%h, expected data=%h strb=%h",
                         bus_write_data, bus_write_strobe, wdata, strb);
            end
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            #1;
            checks++;
            if (bus_read_request !== 1'b0 || bus_write_request !== 1'b0 || grant !== g ||
                bus_rw_address !== addr) begin
                errors++;
                $display("FAIL wait_hold rd=%b wr=%b grant=%b addr=%h, expected rd=0 wr=0 grant=%b addr=%h",
                         bus_read_request, bus_write_request, grant, bus_rw_address, g, addr);
            end
        end
        bus_read_data = rdata;
        if (wr) bus_write_response = 1'b1;
        else    bus_read_response  = 1'b1;
        sb.push_back('{idx: idx, wr: wr, data: rdata, tmo: 1'b0});
        tick();
        clear_mgr();
        bus_read_response  = 1'b0;
        bus_write_response = 1'b0;
        #1;
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL grant_clear grant=%b, expected 00", grant);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (grant !== '0 || bus_read_request !== 1'b0 || bus_write_request !== 1'b0 ||
            bus_rw_address !== '0 || bus_write_data !== '0 || bus_write_strobe !== '0 ||
            mgr_read_response !== '0 || mgr_write_response !== '0 || timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL %s grant=%b rreq=%b wreq=%b addr=%h wd=%h st=%h rrsp=%b wrsp=%b tmo=%b, expected all 0",
                     name, grant, bus_read_request, bus_write_request, bus_rw_address, bus_write_data,
                     bus_write_strobe, mgr_read_response, mgr_write_response, timeout_error);
        end
    endtask

    task automatic test_reset();
        int n;
        #1 reset = 1'b0;
        #1;
        check_all_zero("reset_initial");
        tick();
        tick();
        reset = 1'b1;
        // Reset in the middle of WAIT drops the transaction.
        set_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        wait_issue(n);
        tick();
        #1;
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL wait_grant grant=%b, expected 01", grant);
        end
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        clear_mgr();
        tick();
        tick();
        reset = 1'b1;
        do_txn(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hA5A5_0001, 1);
    endtask

    task automatic test_single_write();
        do_txn(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 3);
    endtask

    task automatic test_contention();
        int n;
        logic [N-1:0] g;
        logic [31:0]  a;
        #1 reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            g = (t % 2 == 0) ? 2'b01 : 2'b10;
            a = (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            wait_issue(n);
            checks++;
            if (n !== 1 || grant !== g || bus_rw_address !== a || bus_read_request !== 1'b1) begin
                errors++;
                $display("FAIL contention_%0d n=%0d grant=%b addr=%h rreq=%b, expected n=1 grant=%b addr=%h rreq=1",
                         t, n, grant, bus_rw_address, bus_read_request, g, a);
            end
            bus_read_data     = 32'hC0DE_0000 + 32'(t);
            bus_read_response = 1'b1;
            sb.push_back('{idx: t % 2, wr: 1'b0, data: 32'hC0DE_0000 + 32'(t), tmo: 1'b0});
            tick();
            bus_read_response = 1'b0;
            if (t == 3) clear_mgr();
        end
    endtask

    task automatic test_conflict();
        int n;
        set_req(0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_1234, 4'h3);
        wait_issue(n);
        checks++;
        if (n !== 1 || bus_write_request !== 1'b1 || bus_read_request !== 1'b0 ||
            bus_write_data !== 32'h0000_1234 || bus_write_strobe !== 4'h3) begin
            errors++;
            $display("FAIL conflict_write n=%0d wreq=%b rreq=%b wd=%h st=%h, expected n=1 wreq=1 rreq=0 wd=00001234 st=3",
                     n, bus_write_request, bus_read_request, bus_write_data, bus_write_strobe);
        end
        bus_write_response = 1'b1;
        sb.push_back('{idx: 0, wr: 1'b1, data: 32'h0, tmo: 1'b0});
        tick();
        bus_write_response    = 1'b0;
        mgr_write_request[0]  = 1'b0;
        wait_issue(n);
        checks++;
        if (n !== 1 || bus_read_request !== 1'b1 || bus_write_request !== 1'b0 || grant !== 2'b01) begin
            errors++;
            $display("FAIL conflict_read n=%0d rreq=%b wreq=%b grant=%b, expected n=1 rreq=1 wreq=0 grant=01",
                     n, bus_read_request, bus_write_request, grant);
        end
        bus_read_data     = 32'h5555_AAAA;
        bus_read_response = 1'b1;
        sb.push_back('{idx: 0, wr: 1'b0, data: 32'h5555_AAAA, tmo: 1'b0});
        tick();
        bus_read_response = 1'b0;
        clear_mgr();
    endtask

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bus_read_data = 32'h1234_5678;
        set_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        wait_issue(n);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (mgr_read_response !== '0 || timeout_error !== 1'b0) begin
                errors++;
                $display("FAIL early_timeout cycle=%0d rrsp=%b tmo=%b, expected 00/0",
                         k, mgr_read_response, timeout_error);
            end
            tick();
            #1;
        end
        sb.push_back('{idx: 0, wr: 1'b0, data: 32'h0, tmo: 1'b1});
        checks++;
        if (mgr_read_response !== 2'b01 || mgr_read_data !== 32'h0 || timeout_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout rrsp=%b data=%h tmo=%b, expected 01/00000000/1",
                     mgr_read_response, mgr_read_data, timeout_error);
        end
        tick();
        clear_mgr();
        bus_read_response = 1'b1;
        #1;
        checks++;
        if (mgr_read_response !== '0 || grant !== '0 || timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL late_response rrsp=%b grant=%b tmo=%b, expected 00/00/0",
                     mgr_read_response, grant, timeout_error);
        end
        tick();
        bus_read_response = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int  n;
        bit  bad;
        bad = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        wait_issue(n);
        for (int k = 0; k < 1000; k++) begin
            tick();
            // A write response during a read must be ignored.
            bus_write_response = (k == 500);
            #1;
            if (!bad && (grant !== 2'b01 || timeout_error !== 1'b0 || bus_read_request !== 1'b0 ||
                         mgr_read_response !== '0 || mgr_write_response !== '0)) begin
                bad = 1'b1;
                $display("FAIL no_timeout cycle=%0d grant=%b tmo=%b rreq=%b rrsp=%b wrsp=%b, expected 01/0/0/00/00",
                         k, grant, timeout_error, bus_read_request, mgr_read_response, mgr_write_response);
            end
        end
        checks++;
        if (bad) errors++;
        bus_write_response = 1'b0;
        bus_read_data      = 32'h0BAD_F00D;
        bus_read_response  = 1'b1;
        sb.push_back('{idx: 0, wr: 1'b0, data: 32'h0BAD_F00D, tmo: 1'b0});
        tick();
        bus_read_response = 1'b0;
        clear_mgr();
        tick();
        bus_read_response = 1'b1;
        #1;
        checks++;
        if (mgr_read_response !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL idle_response rrsp=%b grant=%b, expected 00/00", mgr_read_response, grant);
        end
        tick();
        bus_read_response = 1'b0;
    endtask
`endif

    initial begin
        reset              = 1'b1;
        bus_read_data      = '0;
        bus_read_response  = 1'b0;
        bus_write_response = 1'b0;
        clear_mgr();
        test_reset();
        test_single_write();
        test_contention();
        test_conflict();
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
